// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Latency: 3 cycles for a branch, 4 for ALU/jump/store, 5 for a load, plus one per memory wait cycle.
// Backpressure: holds in FETCH until imem_ready and in MEM until dmem_ready; outputs stay stable while waiting.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   opcode, func3, func7       instruction register fields (stable from DECODE until the next FETCH)
//   imem_ready, dmem_ready     memory completion strobes (ignored while the matching request is low)
//   imem_req, ir_we            instruction fetch request / instruction register load
//   dmem_req, mwe, memi        data access request, write enable, {2'b00,func3} size/sign
//   aop, srcA, srcB, ws        ALU operation, operand selects, register-file write source
//   rfwe, enpc, jal, jalr, b   register write, PC update strobe and PC target selects
//   halted, illegal, instret   halt status, unknown-opcode flag, retired-instruction count
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        mwe,
  output logic [4:0]  memi,
  output logic [4:0]  aop,
  output logic [1:0]  srcA,
  output logic [2:0]  srcB,
  output logic        ws,
  output logic        rfwe,
  output logic        enpc,
  output logic        jal,
  output logic        jalr,
  output logic        b,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OPC_R      = 7'd51;
  localparam logic [6:0] OPC_I      = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_HALT   = 7'd115;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  // Cleared by reset and set on the first clock edge after release, so the
  // fetch request only appears once reset has been synchronously released.
  logic        r_run;
  logic        r_illegal;
  logic [31:0] r_instret;
  logic        w_set_illegal;
  logic        w_legal;
  logic        w_unused;

  // Only the two top func7 bits feed the ALU opcode.
  assign w_unused = &{1'b0, func7[4:0]};

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Sticky illegal flag and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      if (w_set_illegal) r_illegal <= 1'b1;
      if (enpc)          r_instret <= r_instret + 32'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_run && imem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next        = S_HALT;
          w_set_illegal = (opcode != OPC_HALT);
        end
      end
      S_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: w_next = S_MEM;
          OPC_BRANCH:          w_next = S_FETCH;
          default:             w_next = S_WB;
        endcase
      end
      S_MEM: begin
        // Only loads and stores reach MEM.
        if (dmem_ready) w_next = (opcode == OPC_STORE) ? S_FETCH : S_WB;
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    mwe      = 1'b0;
    memi     = 5'd0;
    aop      = 5'd0;
    srcA     = 2'd0;
    srcB     = 3'd0;
    ws       = 1'b0;
    rfwe     = 1'b0;
    enpc     = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    b        = 1'b0;
    halted   = (r_state == S_HALT);
    illegal  = r_illegal;
    instret  = r_instret;
    case (r_state)
      S_FETCH: begin
        imem_req = r_run;
        ir_we    = r_run && imem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OPC_R: begin
            aop = {func7[6:5], func3};
          end
          OPC_I: begin
            srcB = 3'd1;
            // Only the shift-right group uses func7 to pick arithmetic vs logical.
            aop  = (func3 == 3'b101) ? {func7[6:5], func3} : {2'b00, func3};
          end
          OPC_LOAD: begin
            srcB = 3'd1;
          end
          OPC_STORE: begin
            srcB = 3'd3;
          end
          OPC_BRANCH: begin
            aop  = {2'b11, func3};
            b    = 1'b1;
            enpc = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            srcA = 2'd1;
            srcB = 3'd4;
          end
          OPC_LUI: begin
            srcA = 2'd2;
            srcB = 3'd2;
          end
          OPC_AUIPC: begin
            srcA = 2'd1;
            srcB = 3'd2;
          end
          default: begin
            aop = 5'd0;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memi     = {2'b00, func3};
        mwe      = (opcode == OPC_STORE);
        enpc     = dmem_ready && (opcode == OPC_STORE);
      end
      S_WB: begin
        rfwe = 1'b1;
        enpc = 1'b1;
        ws   = (opcode == OPC_LOAD);
        jal  = (opcode == OPC_JAL);
        jalr = (opcode == OPC_JALR);
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: randomized instruction stream against a per-instruction expected trace.
// Latency: each instruction's expected cycle sequence is derived from its class and chosen wait states.
// Backpressure: ready strobes are randomized whenever the matching request is expected low.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        mwe;
  logic [4:0]  memi;
  logic [4:0]  aop;
  logic [1:0]  srcA;
  logic [2:0]  srcB;
  logic        ws;
  logic        rfwe;
  logic        enpc;
  logic        jal;
  logic        jalr;
  logic        b;
  logic        halted;
  logic        illegal;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .mwe(mwe), .memi(memi), .aop(aop), .srcA(srcA), .srcB(srcB),
    .ws(ws), .rfwe(rfwe), .enpc(enpc), .jal(jal), .jalr(jalr), .b(b),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic       imem_req, ir_we, dmem_req, mwe;
    logic [4:0] memi, aop;
    logic [1:0] srca;
    logic [2:0] srcb;
    logic       ws, rfwe, enpc, jal, jalr, b, halted, illegal;
  } outs_t;

  // One expected cycle: outputs plus the ready values to drive (or randomize).
  typedef struct {
    outs_t exp;
    logic  ir;
    logic  dr;
    bit    irr;
    bit    drr;
    bit    fix;
  } step_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_cnt  = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t obs();
    outs_t o;
    o = '{imem_req, ir_we, dmem_req, mwe, memi, aop, srcA, srcB,
          ws, rfwe, enpc, jal, jalr, b, halted, illegal};
    return o;
  endfunction

  function automatic bit is_legal(input logic [6:0] opc);
    return opc inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};
  endfunction

  // Builds the expected cycle trace of one instruction from the ISA-level rules,
  // then drives it and compares outputs and instret every cycle (up to 'stop' cycles).
  task automatic run_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input int iw, input int dw, input int stop);
    step_t q[$];
    outs_t e;
    bit    ld, st, br;
    ld = (opc == 7'd3);
    st = (opc == 7'd35);
    br = (opc == 7'd99);
    for (int k = 0; k <= iw; k++) begin
      e = '0; e.imem_req = 1'b1; e.ir_we = (k == iw);
      q.push_back('{e, (k == iw), 1'b0, 1'b0, 1'b1, 1'b0});
    end
    e = '0;
    q.push_back('{e, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    if (!is_legal(opc)) begin
      for (int k = 0; k < 20; k++) begin
        e = '0; e.halted = 1'b1; e.illegal = (opc != 7'd115);
        q.push_back('{e, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      end
    end else begin
      e = '0;
      case (opc)
        7'd51:  e.aop = {f7[6:5], f3};
        7'd19:  begin e.srcb = 3'd1; e.aop = (f3 == 3'd5) ? {f7[6:5], f3} : {2'b00, f3}; end
        7'd3:   e.srcb = 3'd1;
        7'd35:  e.srcb = 3'd3;
        7'd99:  begin e.aop = {2'b11, f3}; e.b = 1'b1; e.enpc = 1'b1; end
        7'd111, 7'd103: begin e.srca = 2'd1; e.srcb = 3'd4; end
        7'd55:  begin e.srca = 2'd2; e.srcb = 3'd2; end
        default: begin e.srca = 2'd1; e.srcb = 3'd2; end
      endcase
      q.push_back('{e, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      if (ld || st) begin
        for (int k = 0; k <= dw; k++) begin
          e = '0; e.dmem_req = 1'b1; e.mwe = st; e.memi = {2'b00, f3};
          e.enpc = st && (k == dw);
          q.push_back('{e, 1'b0, (k == dw), 1'b1, 1'b0, 1'b1});
        end
      end
      if (!st && !br) begin
        e = '0; e.rfwe = 1'b1; e.enpc = 1'b1; e.ws = ld;
        e.jal = (opc == 7'd111); e.jalr = (opc == 7'd103);
        q.push_back('{e, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      end
    end
    foreach (q[i]) begin
      if (i < stop) begin
        @(negedge clk);
        opcode     = q[i].fix ? opc : 7'($urandom);
        func3      = q[i].fix ? f3  : 3'($urandom);
        func7      = q[i].fix ? f7  : 7'($urandom);
        imem_ready = q[i].irr ? 1'($urandom) : q[i].ir;
        dmem_ready = q[i].drr ? 1'($urandom) : q[i].dr;
        #1;
        chk($sformatf("%s.c%0d.outs", name, i), 32'(obs()), 32'(q[i].exp));
        chk($sformatf("%s.c%0d.instret", name, i), instret, m_cnt);
        if (q[i].exp.enpc) m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  // Asserts reset mid-cycle (no clock edge), checks the immediate effect, then releases it.
  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    m_cnt      = 32'd0;
    #1;
    chk("rst.outs", 32'(obs()), 32'd0);
    chk("rst.instret", instret, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold.outs", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.outs", 32'(obs()), 32'd0);
  endtask

  logic [6:0] legal_ops [9] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};

  initial begin
    logic [6:0] opc;
    logic [6:0] f7;
    rst_n      = 1'b1;
    opcode     = 7'd0;
    func3      = 3'd0;
    func7      = 7'd0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #2;
    do_reset();

    run_instr("add",  7'd51, 3'd0, 7'h00, 0, 0, 1000);
    run_instr("sub",  7'd51, 3'd0, 7'h20, 0, 0, 1000);
    run_instr("srai", 7'd19, 3'd5, 7'h20, 0, 0, 1000);
    run_instr("slli", 7'd19, 3'd1, 7'h00, 0, 0, 1000);
    run_instr("addi_f7", 7'd19, 3'd0, 7'h20, 1, 0, 1000);
    run_instr("lw_wait", 7'd3, 3'd2, 7'h00, 0, 3, 1000);
    run_instr("sb",   7'd35, 3'd0, 7'h00, 0, 0, 1000);
    run_instr("beq",  7'd99, 3'd0, 7'h00, 0, 0, 1000);
    run_instr("jal",  7'd111, 3'd0, 7'h00, 2, 0, 1000);
    run_instr("jalr", 7'd103, 3'd0, 7'h00, 0, 0, 1000);
    run_instr("lui",  7'd55, 3'd0, 7'h00, 0, 0, 1000);
    run_instr("auipc", 7'd23, 3'd0, 7'h00, 0, 0, 1000);

    for (int n = 0; n < 150; n++) begin
      opc = legal_ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      run_instr($sformatf("rnd%0d", n), opc, 3'($urandom), f7,
                $urandom_range(0, 2), $urandom_range(0, 3), 1000);
    end

    // Reset while a load waits in MEM: the data request must drop without a clock edge.
    run_instr("lw_cut", 7'd3, 3'd2, 7'h00, 0, 10, 6);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("pre_rst.dmem_req", 32'(dmem_req), 32'd1);
    do_reset();
    run_instr("post_rst", 7'd51, 3'd7, 7'h00, 0, 0, 1000);

    // Counter wrap: park the count at its maximum, then retire two instructions.
    @(negedge clk);
    imem_ready = 1'b0;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    m_cnt = 32'hFFFF_FFFF;
    run_instr("wrap", 7'd99, 3'd1, 7'h00, 0, 0, 1000);
    run_instr("wrap2", 7'd19, 3'd0, 7'h00, 0, 0, 1000);

    run_instr("ecall", 7'd115, 3'd0, 7'h00, 0, 0, 1000);
    @(negedge clk);
    do_reset();
    run_instr("pre_ill", 7'd35, 3'd2, 7'h00, 1, 1, 1000);
    run_instr("illegal", 7'h7F, 3'd0, 7'h00, 0, 0, 1000);
    @(negedge clk);
    do_reset();
    run_instr("after_ill", 7'd3, 3'd4, 7'h00, 0, 0, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
